minim_ctrl: RTL and testbench
=============================

Name: minim_ctrl

Overview:
- Parametrised sequencer between the input FIFO, the minimiser FSM and the serial transmitter.
- Per job it:
  - pops one FIFO entry;
  - forwards the entry's error code directly to the transmitter, or starts the minimiser;
  - buffers the minimiser's result words in a local array;
  - sends the buffered words one at a time through the transmitter handshake.
- Compared with the previous controller it adds:
  - a parametrised result width and buffer depth;
  - an explicit per-word valid signal on results;
  - a minimiser watchdog;
  - result-count overflow protection;
  - a controller-generated error code.

Parameters:
- RES_W, 10: width of one minimiser result word.
- DEPTH, 16: result buffer entries (power of 2, ≥ 2).
- CNT_W, 6: width of result count; must satisfy 2^CNT_W > DEPTH.
- ERR_W, 3: width of error code.
- TIMEOUT, 1024: maximum cycles from min_start until min_done; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO holds no entry.
- fifo_rd  out  1  one-cycle pop strobe.
- fifo_err  in  ERR_W  error code of the popped entry; valid 2 cycles after fifo_rd.
- min_start  out  1  one-cycle start pulse to the minimiser.
- min_done  in  1  pulse: result count is valid.
- min_count  in  CNT_W  number of result words that will follow.
- min_res_vld  in  1  result word strobe.
- min_res  in  RES_W  result word.
- tx_send  out  1  one-cycle send request.
- tx_data  out  RES_W  word to send; held stable until tx_ready.
- tx_err  out  ERR_W  error code to send; 0 means a data word.
- tx_ready  in  1  transmitter has finished the current frame.
- busy  out  1  controller is not in IDLE.
- ovf_cnt  out  8  saturating count of overflow/timeout events.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE;
  - fifo_rd, min_start, tx_send = 0;
  - tx_data, tx_err = 0;
  - wr_ptr, rd_ptr, count register, watchdog = 0;
  - ovf_cnt = 0;
  - buffer contents undefined.
- Reset mid-job abandons the job. No partial frame is re-sent after reset release.
- IDLE: if !fifo_empty, assert fifo_rd for one cycle and go to POP1.
- POP1 → POP2: one cycle each (FIFO read latency). fifo_err is sampled in POP2:
  - nonzero: load tx_err = fifo_err, go to ERR_SEND;
  - zero: assert min_start for one cycle, clear the watchdog, go to WAIT_DONE.
- WAIT_DONE:
  - The watchdog increments each cycle.
  - On min_done, latch cnt = min(min_count, DEPTH):
    - if min_count > DEPTH, set the ovf flag;
    - if min_count == 0, go to IDLE (no frames sent);
    - otherwise go to COLLECT with wr_ptr = 0.
  - If the watchdog reaches TIMEOUT-1 with no min_done: tx_err = all-ones ("7" at ERR_W = 3), ovf_cnt += 1 (saturating), go to ERR_SEND.
- COLLECT:
  - On each min_res_vld with wr_ptr < cnt: buf[wr_ptr] = min_res, wr_ptr += 1.
  - Words beyond cnt are dropped.
  - When wr_ptr == cnt (checked the cycle after the last write), go to SEND with rd_ptr = 0.
  - If the ovf flag is set, ovf_cnt += 1 on exit.
- min_res_vld in the same cycle as min_done is ignored. Words may arrive with gaps.
- SEND:
  - if rd_ptr < cnt: tx_data = buf[rd_ptr], tx_err = 0, tx_send = 1 for one cycle, go to SEND_WAIT;
  - else clear the pointers and go to IDLE.
- SEND_WAIT: on tx_ready, rd_ptr += 1 and go to SEND. tx_ready in the same cycle as tx_send is ignored (it belongs to the previous frame).
- ERR_SEND: tx_send = 1 for one cycle, go to ERR_WAIT.
- ERR_WAIT: on tx_ready, clear tx_err and go to IDLE.
- busy = (state != IDLE). The back-to-back IDLE re-entry cost is exactly 1 cycle.
- Latency, error entry: from fifo_rd to tx_send is 3 cycles.
- Latency, data entry: from fifo_rd to min_start is 2 cycles.
- Widths:
  - pointers are $clog2(DEPTH)+1 bits;
  - comparisons are unsigned;
  - ovf_cnt saturates at 255 and never wraps.

Decomposition:
- Package minim_pkg:
  - state enum (IDLE, POP1, POP2, WAIT_DONE, COLLECT, SEND, SEND_WAIT, ERR_SEND, ERR_WAIT);
  - ERR_TIMEOUT constant (all-ones);
  - default widths.
- One sub-module, minim_resbuf: a DEPTH×RES_W register file with a synchronous write port and a combinational read port.

Test Plan:
- FIFO entry with fifo_err = 3 → exactly one tx_send with tx_err = 3; min_start never asserted; state back to IDLE after tx_ready.
- Clean entry, min_count = 4, words 0x001/0x2AA/0x155/0x3FF with 1-cycle gaps → 4 tx_send pulses, tx_data in that order, tx_err = 0 on each.
- min_count = 20 with DEPTH = 16, 20 words → exactly 16 frames sent (the first 16 words), ovf_cnt = 1.
- min_done withheld, TIMEOUT = 8 → tx_err = 7 frame 8 cycles after min_start; ovf_cnt increments.
- min_count = 0 → no tx_send; busy drops 1 cycle after min_done.
- Assert rst_n low during SEND_WAIT of frame 2 of 4 → all outputs 0 immediately; after release with the FIFO empty, no further tx_send.

Source files
------------

// File: rtl/minim_pkg.sv
// Shared types and defaults for the minimiser sequencer.
// Imported by the controller and its result buffer.
package minim_pkg;

    localparam int DEF_RES_W   = 10;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_CNT_W   = 6;
    localparam int DEF_ERR_W   = 3;
    localparam int DEF_TIMEOUT = 1024;

    // Truncated to ERR_W at the point of use, so it stays all-ones.
    localparam logic [31:0] ERR_TIMEOUT = '1;

    typedef enum logic [3:0] {
        IDLE,
        POP1,
        POP2,
        WAIT_DONE,
        COLLECT,
        SEND,
        SEND_WAIT,
        ERR_SEND,
        ERR_WAIT
    } state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/minim_resbuf.sv
// Result word store: synchronous write, combinational read.
// Contents are not reset; the controller only reads written slots.
module minim_resbuf
    import minim_pkg::*;
#(
    parameter int RES_W = DEF_RES_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [RES_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [RES_W-1:0]         rdata
);

    logic [RES_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/minim_ctrl.sv
// Sequencer: FIFO pop -> minimiser run or error forward -> buffered
// result words sent one frame at a time to the serial transmitter.
module minim_ctrl
    import minim_pkg::*;
#(
    parameter int RES_W   = DEF_RES_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ERR_W   = DEF_ERR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [ERR_W-1:0] fifo_err,
    output logic             min_start,
    input  logic             min_done,
    input  logic [CNT_W-1:0] min_count,
    input  logic             min_res_vld,
    input  logic [RES_W-1:0] min_res,
    output logic             tx_send,
    output logic [RES_W-1:0] tx_data,
    output logic [ERR_W-1:0] tx_err,
    input  logic             tx_ready,
    output logic             busy,
    output logic [7:0]       ovf_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam bit               WD_EN   = (TIMEOUT != 0);

    state_e           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] cnt;
    logic             ovf;
    logic [WD_W-1:0]  wd;
    logic             we;
    logic [RES_W-1:0] rdata;

    assign we   = (state == COLLECT) && min_res_vld && (wr_ptr < cnt);
    assign busy = (state != IDLE);

    minim_resbuf #(
        .RES_W (RES_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (min_res),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fifo_rd   <= 1'b0;
            min_start <= 1'b0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            tx_err    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            wd        <= '0;
            ovf_cnt   <= '0;
        end else begin
            fifo_rd   <= 1'b0;
            min_start <= 1'b0;
            tx_send   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd <= 1'b1;
                        state   <= POP1;
                    end
                end
                POP1: begin
                    state <= POP2;
                end
                POP2: begin
                    if (fifo_err != '0) begin
                        tx_err <= fifo_err;
                        state  <= ERR_SEND;
                    end else begin
                        min_start <= 1'b1;
                        wd        <= '0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    wd <= wd + 1'b1;
                    if (min_done) begin
                        if (min_count > DEPTH_C) begin
                            cnt <= DEPTH_P;
                            ovf <= 1'b1;
                        end else begin
                            cnt <= PTR_W'(min_count);
                            ovf <= 1'b0;
                        end
                        wr_ptr <= '0;
                        if (min_count == '0) begin
                            state <= IDLE;
                        end else begin
                            state <= COLLECT;
                        end
                    end else if (WD_EN && wd == WD_LAST) begin
                        tx_err  <= ERR_W'(ERR_TIMEOUT);
                        ovf_cnt <= sat_inc(ovf_cnt);
                        state   <= ERR_SEND;
                    end
                end
                COLLECT: begin
                    // Exit is seen the cycle after the last write lands.
                    if (wr_ptr == cnt) begin
                        rd_ptr <= '0;
                        state  <= SEND;
                        if (ovf) begin
                            ovf_cnt <= sat_inc(ovf_cnt);
                            ovf     <= 1'b0;
                        end
                    end else if (min_res_vld) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                SEND: begin
                    if (rd_ptr < cnt) begin
                        tx_data <= rdata;
                        tx_err  <= '0;
                        tx_send <= 1'b1;
                        state   <= SEND_WAIT;
                    end else begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                end
                SEND_WAIT: begin
                    // A ready alongside our own send closes the previous frame.
                    if (tx_ready && !tx_send) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= SEND;
                    end
                end
                ERR_SEND: begin
                    tx_send <= 1'b1;
                    state   <= ERR_WAIT;
                end
                ERR_WAIT: begin
                    if (tx_ready && !tx_send) begin
                        tx_err <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minim_ctrl.sv
// Randomised bench for minim_ctrl: FIFO, minimiser and transmitter
// models drive the DUT; expected frames come from the job descriptions.
module tb_minim_ctrl;

    localparam int RES_W   = 10;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 6;
    localparam int ERR_W   = 3;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [ERR_W-1:0] fifo_err;
    logic             min_start;
    logic             min_done;
    logic [CNT_W-1:0] min_count;
    logic             min_res_vld;
    logic [RES_W-1:0] min_res;
    logic             tx_send;
    logic [RES_W-1:0] tx_data;
    logic [ERR_W-1:0] tx_err;
    logic             tx_ready;
    logic             busy;
    logic [7:0]       ovf_cnt;

    minim_ctrl #(
        .RES_W   (RES_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .ERR_W   (ERR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .fifo_err    (fifo_err),
        .min_start   (min_start),
        .min_done    (min_done),
        .min_count   (min_count),
        .min_res_vld (min_res_vld),
        .min_res     (min_res),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_err      (tx_err),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    int jq_err[$];
    int jq_cnt[$];
    bit jq_to[$];
    int wq[$];
    int exp_err[$];
    int exp_dat[$];
    int fixed_w[$];

    int exp_ovf    = 0;
    int exp_starts = 0;
    int starts     = 0;
    int frames     = 0;

    int cur_err, cur_cnt;
    bit cur_to;
    int rd_cyc, start_cyc;
    int busy_at = -1;
    bit first_tx, to_watch;

    int mm_phase  = 0;
    int mm_delay, mm_left, mm_gap;
    int mm_gapmin = 0;
    int mm_gapmax = 2;

    bit tx_pend = 0;
    bit stale   = 0;
    int tx_delay, pend_err, pend_dat;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    function automatic int sat255(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Queue one FIFO entry and derive everything the DUT should emit for it.
    task automatic push_job(input int err, input int cnt, input bit to);
        jq_err.push_back(err);
        jq_cnt.push_back(cnt);
        jq_to.push_back(to);
        if (err != 0) begin
            exp_err.push_back(err);
            exp_dat.push_back(0);
        end else begin
            exp_starts++;
            if (to) begin
                exp_err.push_back(7);
                exp_dat.push_back(0);
                exp_ovf = sat255(exp_ovf);
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    int w;
                    if (i < fixed_w.size()) w = fixed_w[i];
                    else w = int'($urandom_range(0, 1023));
                    wq.push_back(w);
                    if (i < DEPTH) begin
                        exp_err.push_back(0);
                        exp_dat.push_back(w);
                    end
                end
                if (cnt > DEPTH) exp_ovf = sat255(exp_ovf);
            end
        end
        fixed_w.delete();
        fifo_empty = 1'b0;
    endtask

    task automatic tick();
        int e, d;
        @(negedge clk);
        cyc++;
        if (fifo_rd) begin
            check_eq("pop_empty", jq_err.size() != 0, 1'b1);
            if (jq_err.size() != 0) begin
                cur_err = jq_err.pop_front();
                cur_cnt = jq_cnt.pop_front();
                cur_to  = jq_to.pop_front();
            end
            fifo_err = ERR_W'(cur_err);
            rd_cyc   = cyc;
            first_tx = 1'b1;
        end
        if (min_start) begin
            starts++;
            check_eq("start_lat", cyc - rd_cyc, 2);
            start_cyc = cyc;
            if (cur_to) begin
                to_watch = 1'b1;
            end else begin
                mm_phase = 1;
                mm_delay = $urandom_range(0, 3);
            end
        end
        if (to_watch && tx_err == 3'd7) begin
            // Watchdog runs 0..TIMEOUT-1 from the start cycle.
            check_eq("to_err_lat", cyc - start_cyc, TIMEOUT);
            to_watch = 1'b0;
        end
        if (cyc == busy_at) begin
            check_eq("busy_drop", busy, 1'b0);
            busy_at = -1;
        end
        if (tx_send) begin
            frames++;
            if (exp_err.size() == 0) begin
                check_eq("extra_frame", tx_send, 1'b0);
                pend_err = 1;
            end else begin
                e = exp_err.pop_front();
                d = exp_dat.pop_front();
                check_eq("frame_err", tx_err, e);
                if (e == 0) check_eq("frame_data", tx_data, d);
                pend_err = e;
                pend_dat = d;
            end
            if (first_tx) begin
                first_tx = 1'b0;
                if (cur_err != 0) check_eq("err_lat", cyc - rd_cyc, 3);
                if (cur_err == 0 && cur_to)
                    check_eq("to_send_lat", cyc - start_cyc, TIMEOUT + 1);
            end
            tx_pend  = 1'b1;
            tx_delay = $urandom_range(1, 4);
            stale    = ($urandom_range(0, 2) == 0);
        end

        min_done    = 1'b0;
        min_res_vld = 1'b0;
        min_res     = RES_W'($urandom);
        tx_ready    = 1'b0;
        if (mm_phase == 1) begin
            if (mm_delay == 0) begin
                min_done  = 1'b1;
                min_count = CNT_W'(cur_cnt);
                if ($urandom_range(0, 1) == 1) min_res_vld = 1'b1;
                if (cur_cnt == 0) busy_at = cyc + 1;
                mm_left  = cur_cnt;
                mm_gap   = $urandom_range(mm_gapmin, mm_gapmax);
                mm_phase = (cur_cnt > 0) ? 2 : 0;
            end else begin
                mm_delay--;
            end
        end else if (mm_phase == 2) begin
            if (mm_gap == 0) begin
                min_res_vld = 1'b1;
                min_res     = RES_W'(wq.pop_front());
                mm_left--;
                mm_gap = $urandom_range(mm_gapmin, mm_gapmax);
                if (mm_left == 0) mm_phase = 0;
            end else begin
                mm_gap--;
            end
        end
        if (stale) begin
            tx_ready = 1'b1;
            stale    = 1'b0;
        end
        if (tx_pend) begin
            if (tx_delay == 0) begin
                if (pend_err == 0) check_eq("tx_hold", tx_data, pend_dat);
                tx_ready = 1'b1;
                tx_pend  = 1'b0;
            end else begin
                tx_delay--;
            end
        end
        fifo_empty = (jq_err.size() == 0);
    endtask

    task automatic drain(input int budget);
        int  n;
        bit  quiet;
        n     = 0;
        quiet = 1'b0;
        while (!quiet && n < budget) begin
            tick();
            n++;
            quiet = (jq_err.size() == 0) && (exp_err.size() == 0) &&
                    (mm_phase == 0) && !tx_pend && !busy;
        end
        check_eq("drain", quiet, 1'b1);
        check_eq("ovf_cnt", ovf_cnt, exp_ovf);
        check_eq("starts", starts, exp_starts);
        check_eq("tx_err_idle", tx_err, 0);
    endtask

    initial begin
        int base;
        rst_n       = 1'b0;
        fifo_empty  = 1'b1;
        fifo_err    = '0;
        min_done    = 1'b0;
        min_count   = '0;
        min_res_vld = 1'b0;
        min_res     = '0;
        tx_ready    = 1'b0;
        repeat (3) tick();
        check_eq("reset_outs",
                 {fifo_rd, min_start, tx_send, tx_data, tx_err, busy, ovf_cnt},
                 0);
        rst_n = 1'b1;

        push_job(3, 0, 1'b0);
        drain(2000);

        mm_gapmin = 1;
        mm_gapmax = 1;
        fixed_w = {'h001, 'h2AA, 'h155, 'h3FF};
        push_job(0, 4, 1'b0);
        drain(2000);
        mm_gapmin = 0;
        mm_gapmax = 2;

        push_job(0, 20, 1'b0);
        drain(2000);

        push_job(0, 0, 1'b1);
        drain(2000);

        push_job(0, 0, 1'b0);
        drain(2000);

        // Reset while the second of four frames is outstanding.
        base = frames;
        push_job(0, 4, 1'b0);
        for (int i = 0; i < 500 && frames - base < 2; i++) tick();
        check_eq("rst_reach", frames - base, 2);
        rst_n = 1'b0;
        #1;
        check_eq("rst_outs",
                 {fifo_rd, min_start, tx_send, tx_data, tx_err, busy, ovf_cnt},
                 0);
        jq_err.delete();
        jq_cnt.delete();
        jq_to.delete();
        wq.delete();
        exp_err.delete();
        exp_dat.delete();
        mm_phase   = 0;
        tx_pend    = 1'b0;
        stale      = 1'b0;
        to_watch   = 1'b0;
        busy_at    = -1;
        exp_ovf    = 0;
        tx_ready   = 1'b0;
        fifo_empty = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        base  = frames;
        repeat (30) tick();
        check_eq("post_rst_frames", frames - base, 0);
        check_eq("post_rst_busy", busy, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int nj;
            mm_gapmax = $urandom_range(0, 3);
            nj = $urandom_range(1, 3);
            for (int j = 0; j < nj; j++) begin
                int k;
                k = $urandom_range(0, 9);
                if (k < 2) push_job($urandom_range(1, 7), 0, 1'b0);
                else if (k == 2) push_job(0, 0, 1'b1);
                else if (k == 3) push_job(0, 0, 1'b0);
                else push_job(0, $urandom_range(1, 24), 1'b0);
            end
            drain(20000);
        end

        // Drive the event counter into saturation.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 45; j++) push_job(0, 0, 1'b1);
            drain(20000);
        end
        check_eq("ovf_sat", ovf_cnt, 8'd255);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
